i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Shares one `i2c_master` instance between `NUM_REQ` requesters, each asking for a single-byte read or write to a 7-bit slave address. It arbitrates round-robin, launches the transaction on the master's command port, and waits for completion, error or timeout. It then returns read data and status to the granted requester. It sits between the system-side clients and the `i2c_master` command/response pins, in the same clock domain.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in `clk` cycles. Used only with `I2C_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request level. Held high until the matching `rsp_valid`.
- `req_read`  in  NUM_REQ  1 = read, 0 = write.
- `req_addr`  in  7*NUM_REQ  slave address. Requester i uses bits [7i+6:7i].
- `req_wdata`  in  8*NUM_REQ  write byte. Requester i uses bits [8i+7:8i].
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rsp_rdata`  out  8  read byte, valid with `rsp_valid`.
- `rsp_error`  out  1  transaction failed (NACK/master error, or timeout).
- `rsp_timeout`  out  1  failure caused by the watchdog.
- `busy`  out  1  high whenever the state is not IDLE.
- `grant_id`  out  3  index of the current/last granted requester.
- `read`, `slave_address[6:0]`, `data_send_master[7:0]`  out  to master. Held stable from LAUNCH through WAIT.
- `data_send_master_enable`  out  1  one-cycle launch strobe to master.
- `data_receive_master[7:0]`, `data_receive_master_enable`  in  master read data and its valid strobe.
- `error_master`  in  1  master error.
- `done_master`  in  1  master transaction-complete pulse (read or write).

## Operation
The FSM has four states: IDLE, LAUNCH, WAIT, RESP.

- **IDLE:** If any `req_valid` is high, pick the first set bit searching from `rr_ptr` upward, wrapping at NUM_REQ. Latch that requester's read flag, address and write byte onto the master outputs and set `grant_id`, then go to LAUNCH. If no request is present, stay in IDLE.
- **LAUNCH:** Assert `data_send_master_enable` for this single cycle. Clear the read-data and status registers and the watchdog counter. Go to WAIT.
- **WAIT:** On `data_receive_master_enable`, capture `data_receive_master`. On `error_master`, set the error flag and go to RESP. On `done_master`, go to RESP.
- **RESP:** Pulse `rsp_valid[grant_id]` for one cycle. Set `rr_ptr` to (grant_id+1) mod NUM_REQ. Go to IDLE.

Priority rules:
- If `error_master` and `done_master` are high in the same cycle, error wins and `rsp_error`=1.
- If data and done arrive in the same cycle, the data is captured.
- `rsp_rdata` reads 0 for writes.

Requester and input rules:
- A requester that drops `req_valid` mid-transaction does not abort it. The transaction completes and the `rsp_valid` pulse is still issued.
- Inputs sampled by the master (`read`, `slave_address`, `data_send_master`) never change while `busy`=1.
- `done_master`, `error_master` and `data_receive_master_enable` arriving outside WAIT are ignored.

Reset behaviour:
- All outputs go to 0: `rsp_*`, `busy`, `grant_id`, and all master-side outputs.
- State goes to IDLE and `rr_ptr` goes to 0.
- Reset mid-transaction drops the transaction without a response.

## Timing
- Request first seen in IDLE at cycle 0. Master outputs are valid and LAUNCH is entered at cycle 1. `data_send_master_enable` is high at cycle 1. WAIT is entered at cycle 2.
- `done_master` at cycle k gives `rsp_valid` at cycle k+1 and IDLE at k+2. The earliest next grant is in cycle k+2, so the minimum gap between launches is 3 cycles plus the master's time.
- The outputs `rsp_rdata`, `rsp_error` and `rsp_timeout` are registered. They hold their values until the next LAUNCH.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A counter runs for the cycles spent in WAIT. It is ceil(log2(TIMEOUT_CYCLES)) bits wide.
  - When the counter reaches TIMEOUT_CYCLES-1 with no done or error, go to RESP with `rsp_error`=1 and `rsp_timeout`=1.
  - If done and timeout coincide, done wins.
  - After a timeout, the next LAUNCH is delayed until `done_master` or `error_master` is seen or 16 idle cycles pass, whichever is first. This stops a late master completion from being attributed to the next transaction.
- Not defined: there is no counter, `rsp_timeout` is tied to 0, and WAIT persists until done or error.

## Structure
- Package `i2c_arb_pkg` holds:
  - the state encoding (IDLE=0, LAUNCH=1, WAIT=2, RESP=3);
  - the address width (7) and data width (8);
  - the `grant_id` width (3).
- Sub-module `i2c_rr_picker`: a combinational round-robin priority picker taking `req_valid` and `rr_ptr`, producing a one-hot grant, `grant_idx` and `any_req`. The FSM, latches and watchdog stay in the top module.

## Test plan
- Single write: req0 (addr 0x50, wdata 0xA5). Master pulses done 20 cycles after launch. Required: one launch strobe, slave_address=0x50, data_send_master=0xA5, `rsp_valid[0]`, `rsp_error`=0, `rsp_rdata`=0x00.
- Single read: req2 (addr 0x3C). Master returns data 0x7E with done. Required: `rsp_valid[2]`, `rsp_rdata`=0x7E, and the 3-cycle launch/response latency above.
- Round-robin: req0..req3 all held high. Required grant order 0,1,2,3,0. No requester is granted twice while another is pending.
- Error: `error_master` and `done_master` raised in the same cycle. Required: `rsp_error`=1, `rsp_timeout`=0, then return to IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=64): master never responds. Required: `rsp_valid` 65 cycles after launch with `rsp_error`=`rsp_timeout`=1. With the macro off, `busy` stays high.
- Reset mid-WAIT: `rst` asserted for 1 cycle. Required: all outputs 0, no `rsp_valid`, and the next grant starts from requester 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the i2c_master_arbiter slice.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } arb_state_e;

  localparam int unsigned AddrWidth  = 7;
  localparam int unsigned DataWidth  = 8;
  localparam int unsigned GrantWidth = 3;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping at NUM_REQ.
module i2c_rr_picker
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [GrantWidth-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]    grant,
  output logic [GrantWidth-1:0] grant_idx,
  output logic                  any_req
);

  localparam logic [GrantWidth:0] NumReqW = (GrantWidth + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   scan;
  logic [GrantWidth-1:0] offset;
  logic [GrantWidth:0]   sum;

  always_comb begin
    // Rotate so bit 0 is the requester at rr_ptr, then find the first set bit.
    doubled = {req_valid, req_valid} >> rr_ptr;
    scan    = doubled[NUM_REQ-1:0];
    any_req = 1'b0;
    offset  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && scan[0]) begin
        any_req = 1'b1;
        offset  = GrantWidth'(i);
      end
      scan = scan >> 1;
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= NumReqW) begin
      sum = sum - NumReqW;
    end
    grant_idx = sum[GrantWidth-1:0];
    grant     = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ single-byte requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [AddrWidth*NUM_REQ-1:0]  req_addr,
  input  logic [DataWidth*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DataWidth-1:0]          rsp_rdata,
  output logic                          rsp_error,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [GrantWidth-1:0]         grant_id,
  output logic                          read,
  output logic [AddrWidth-1:0]          slave_address,
  output logic [DataWidth-1:0]          data_send_master,
  output logic                          data_send_master_enable,
  input  logic [DataWidth-1:0]          data_receive_master,
  input  logic                          data_receive_master_enable,
  input  logic                          error_master,
  input  logic                          done_master
);

  arb_state_e state_q, state_d;

  logic [GrantWidth-1:0] rr_ptr_q, grant_id_q, pick_idx;
  logic [NUM_REQ-1:0]    pick_grant;
  logic                  any_req;
  logic                  pick_read;
  logic [AddrWidth-1:0]  pick_addr, addr_q;
  logic [DataWidth-1:0]  pick_wdata, wdata_q, rdata_q;
  logic                  read_q, error_q, timeout_q;
  logic                  launch_go, launch_allowed, timeout_hit;

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  // AND-OR mux of the granted requester's fields, shifting to keep indices constant.
  logic [NUM_REQ-1:0]           gscan, rscan;
  logic [AddrWidth*NUM_REQ-1:0] ascan;
  logic [DataWidth*NUM_REQ-1:0] dscan;

  always_comb begin
    gscan      = pick_grant;
    rscan      = req_read;
    ascan      = req_addr;
    dscan      = req_wdata;
    pick_read  = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gscan[0]) begin
        pick_read  = pick_read | rscan[0];
        pick_addr  = pick_addr | ascan[AddrWidth-1:0];
        pick_wdata = pick_wdata | dscan[DataWidth-1:0];
      end
      gscan = gscan >> 1;
      rscan = rscan >> 1;
      ascan = ascan >> AddrWidth;
      dscan = dscan >> DataWidth;
    end
  end

  assign launch_go = (state_q == StIdle) && any_req && launch_allowed;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WdWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WdWidth-1:0] wd_cnt_q;
  logic               holdoff_q;
  logic [3:0]         holdoff_cnt_q;

  assign timeout_hit = (state_q == StWait) && (wd_cnt_q == WdWidth'(TIMEOUT_CYCLES - 1)) &&
                       !done_master && !error_master;
  assign launch_allowed = !holdoff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == StLaunch) begin
      wd_cnt_q <= '0;
    end else if (state_q == StWait) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  // After a timeout, hold off launching until the stale master finishes or 16 idle cycles pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff_q     <= 1'b0;
      holdoff_cnt_q <= '0;
    end else if (timeout_hit) begin
      holdoff_q     <= 1'b1;
      holdoff_cnt_q <= '0;
    end else if (holdoff_q) begin
      if (done_master || error_master) begin
        holdoff_q <= 1'b0;
      end else if (state_q == StIdle) begin
        if (holdoff_cnt_q == 4'd15) begin
          holdoff_q <= 1'b0;
        end else begin
          holdoff_cnt_q <= holdoff_cnt_q + 4'd1;
        end
      end
    end
  end
`else
  assign timeout_hit    = 1'b0;
  assign launch_allowed = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (launch_go) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (error_master || done_master || timeout_hit) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    data_send_master_enable = 1'b0;
    rsp_valid               = '0;
    busy                    = (state_q != StIdle);
    unique case (state_q)
      StLaunch: data_send_master_enable = 1'b1;
      StResp:   rsp_valid = NUM_REQ'(1) << grant_id_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      read_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (launch_go) begin
            grant_id_q <= pick_idx;
            read_q     <= pick_read;
            addr_q     <= pick_addr;
            wdata_q    <= pick_wdata;
          end
        end
        StLaunch: begin
          rdata_q   <= '0;
          error_q   <= 1'b0;
          timeout_q <= 1'b0;
        end
        StWait: begin
          // Writes never capture, so rsp_rdata stays 0 for them.
          if (data_receive_master_enable && read_q) rdata_q <= data_receive_master;
          if (error_master || timeout_hit) error_q <= 1'b1;
          if (timeout_hit) timeout_q <= 1'b1;
        end
        StResp: begin
          rr_ptr_q <= (grant_id_q == GrantWidth'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant_id         = grant_id_q;
  assign read             = read_q;
  assign slave_address    = addr_q;
  assign data_send_master = wdata_q;
  assign rsp_rdata        = rdata_q;
  assign rsp_error        = error_q;
  assign rsp_timeout      = timeout_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter with a round-robin reference model.
module tb_i2c_master_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_read;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0] rsp_valid;
  logic [7:0]   rsp_rdata;
  logic         rsp_error, rsp_timeout, busy;
  logic [2:0]   grant_id;
  logic         read;
  logic [6:0]   slave_address;
  logic [7:0]   data_send_master;
  logic         data_send_master_enable;
  logic [7:0]   data_receive_master;
  logic         data_receive_master_enable, error_master, done_master;

  int checks = 0;
  int errors = 0;

  // Reference model: pending set, per-requester fields, round-robin pointer.
  bit [N-1:0] m_pend;
  logic       m_rd[N];
  logic [6:0] m_addr[N];
  logic [7:0] m_wd[N];
  int         m_ptr;

  i2c_master_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .req_valid                  (req_valid),
    .req_read                   (req_read),
    .req_addr                   (req_addr),
    .req_wdata                  (req_wdata),
    .rsp_valid                  (rsp_valid),
    .rsp_rdata                  (rsp_rdata),
    .rsp_error                  (rsp_error),
    .rsp_timeout                (rsp_timeout),
    .busy                       (busy),
    .grant_id                   (grant_id),
    .read                       (read),
    .slave_address              (slave_address),
    .data_send_master           (data_send_master),
    .data_send_master_enable    (data_send_master_enable),
    .data_receive_master        (data_receive_master),
    .data_receive_master_enable (data_receive_master_enable),
    .error_master               (error_master),
    .done_master                (done_master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (m_pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic rd, input logic [6:0] a, input logic [7:0] w);
    req_valid[i] = 1'b1;
    req_read[i]  = rd;
    req_addr[i*7 +: 7]  = a;
    req_wdata[i*8 +: 8] = w;
    m_pend[i] = 1'b1;
    m_rd[i]   = rd;
    m_addr[i] = a;
    m_wd[i]   = w;
  endtask

  task automatic retire(input int g);
    req_valid[g] = 1'b0;
    m_pend[g]    = 1'b0;
    m_ptr        = (g + 1) % N;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    done_master = 1'b0;
    error_master = 1'b0;
    data_receive_master_enable = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_pend = '0;
    m_ptr = 0;
  endtask

  // Steps until the launch strobe is seen; cyc = steps taken (200 = never seen).
  task automatic wait_launch(output int cyc);
    cyc = 0;
    while (!data_send_master_enable && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  // Called in the LAUNCH cycle: waits lat WAIT cycles, then completes and samples the response.
  task automatic finish_txn(input int lat, input bit err, input bit dat, input logic [7:0] d,
                            output logic [N-1:0] rv, output logic [7:0] rdat,
                            output logic rerr, output logic rtmo, output bit stable,
                            output int extra);
    logic [6:0] sa;
    logic [7:0] sd;
    logic       rdf;
    sa = slave_address;
    sd = data_send_master;
    rdf = read;
    stable = 1'b1;
    extra = 0;
    step();
    for (int c = 0; c <= lat; c++) begin
      if (slave_address !== sa || data_send_master !== sd || read !== rdf) stable = 1'b0;
      if (data_send_master_enable || rsp_valid !== '0) extra++;
      if (c < lat) step();
    end
    done_master = 1'b1;
    error_master = err;
    data_receive_master_enable = dat;
    data_receive_master = d;
    step();
    done_master = 1'b0;
    error_master = 1'b0;
    data_receive_master_enable = 1'b0;
    rv = rsp_valid;
    rdat = rsp_rdata;
    rerr = rsp_error;
    rtmo = rsp_timeout;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %0h exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d exp 0", grant_id); end
    checks++; if ({read, slave_address, data_send_master, data_send_master_enable} !== 17'd0) begin
      errors++; $display("FAIL reset_master_outs: got %0h exp 0",
                         {read, slave_address, data_send_master, data_send_master_enable});
    end
    checks++; if ({rsp_rdata, rsp_error, rsp_timeout} !== 10'd0) begin
      errors++; $display("FAIL reset_rsp_regs: got %0h exp 0", {rsp_rdata, rsp_error, rsp_timeout});
    end
    // Master strobes outside WAIT must be ignored.
    done_master = 1'b1; error_master = 1'b1; data_receive_master_enable = 1'b1;
    data_receive_master = 8'hFF;
    step();
    done_master = 1'b0; error_master = 1'b0; data_receive_master_enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || rsp_valid !== '0 || rsp_rdata !== 8'h00) begin
      errors++; $display("FAIL idle_ignore: got busy=%0b rv=%0h rd=%0h exp 0/0/0", busy, rsp_valid,
                         rsp_rdata);
    end
  endtask

  task automatic test_single_write();
    int cyc, extra; bit stable; logic [N-1:0] rv; logic [7:0] rd; logic re, rt;
    set_req(0, 1'b0, 7'h50, 8'hA5);
    wait_launch(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_launch_latency: got %0d exp 1", cyc); end
    checks++; if (slave_address !== 7'h50 || data_send_master !== 8'hA5 || read !== 1'b0) begin
      errors++; $display("FAIL wr_master_outs: got %0h/%0h/%0b exp 50/a5/0", slave_address,
                         data_send_master, read);
    end
    finish_txn(19, 1'b0, 1'b0, 8'h00, rv, rd, re, rt, stable, extra);
    checks++; if (extra !== 0 || !stable) begin
      errors++; $display("FAIL wr_wait_clean: got extra=%0d stable=%0b exp 0/1", extra, stable);
    end
    checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL wr_rsp_valid: got %0b exp 0001", rv); end
    checks++; if (re !== 1'b0 || rd !== 8'h00) begin
      errors++; $display("FAIL wr_rsp: got err=%0b rdata=%0h exp 0/00", re, rd);
    end
    retire(0);
    step();
    checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin
      errors++; $display("FAIL wr_back_idle: got busy=%0b rv=%0h exp 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_single_read();
    int cyc, extra; bit stable; logic [N-1:0] rv; logic [7:0] rd; logic re, rt;
    set_req(2, 1'b1, 7'h3C, 8'h00);
    wait_launch(cyc);
    checks++; if (cyc !== 1 || grant_id !== 3'd2 || read !== 1'b1 || slave_address !== 7'h3C) begin
      errors++; $display("FAIL rd_launch: got cyc=%0d gid=%0d rd=%0b sa=%0h exp 1/2/1/3c", cyc,
                         grant_id, read, slave_address);
    end
    finish_txn($urandom_range(0, 6), 1'b0, 1'b1, 8'h7E, rv, rd, re, rt, stable, extra);
    checks++; if (rv !== 4'b0100 || rd !== 8'h7E || re !== 1'b0) begin
      errors++; $display("FAIL rd_rsp: got rv=%0b rdata=%0h err=%0b exp 0100/7e/0", rv, rd, re);
    end
    retire(2);
    step();
    checks++; if (rsp_rdata !== 8'h7E) begin
      errors++; $display("FAIL rd_hold: got %0h exp 7e", rsp_rdata);
    end
  endtask

  task automatic test_error();
    int cyc, extra; bit stable; logic [N-1:0] rv; logic [7:0] rd; logic re, rt;
    set_req(1, 1'b0, 7'h11, 8'h22);
    wait_launch(cyc);
    finish_txn(3, 1'b1, 1'b0, 8'h00, rv, rd, re, rt, stable, extra);
    checks++; if (rv !== 4'b0010 || re !== 1'b1 || rt !== 1'b0) begin
      errors++; $display("FAIL err_rsp: got rv=%0b err=%0b tmo=%0b exp 0010/1/0", rv, re, rt);
    end
    retire(1);
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: got %0b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    int cyc, extra; bit stable; logic [N-1:0] rv; logic [7:0] rd; logic re, rt;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'($urandom), 8'($urandom));
    for (int t = 0; t < 5; t++) begin
      wait_launch(cyc);
      checks++; if (grant_id !== 3'(order[t]) || slave_address !== m_addr[order[t]]) begin
        errors++; $display("FAIL rr_grant%0d: got gid=%0d sa=%0h exp %0d/%0h", t, grant_id,
                           slave_address, order[t], m_addr[order[t]]);
      end
      finish_txn($urandom_range(0, 4), 1'b0, 1'b0, 8'h00, rv, rd, re, rt, stable, extra);
      checks++; if (rv !== 4'(1 << order[t])) begin
        errors++; $display("FAIL rr_rsp%0d: got %0b exp %0b", t, rv, 4'(1 << order[t]));
      end
      m_ptr = (order[t] + 1) % N;
    end
    req_valid = '0;
    m_pend = '0;
    step();
  endtask

  task automatic test_random();
    int cyc, extra, g, lat; bit stable, err, dat, drop; logic [N-1:0] rv; logic [7:0] rd, d;
    logic re, rt, exp_rd;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!m_pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
      if (m_pend == '0) set_req($urandom_range(0, N - 1), 1'($urandom), 7'($urandom), 8'($urandom));
      g = model_pick();
      wait_launch(cyc);
      checks++; if (cyc >= 200 || grant_id !== 3'(g) || slave_address !== m_addr[g] ||
                    read !== m_rd[g] || data_send_master !== m_wd[g]) begin
        errors++; $display("FAIL rand_launch%0d: got cyc=%0d gid=%0d sa=%0h rd=%0b wd=%0h exp gid=%0d sa=%0h rd=%0b wd=%0h",
                           t, cyc, grant_id, slave_address, read, data_send_master, g, m_addr[g],
                           m_rd[g], m_wd[g]);
      end
      err = ($urandom_range(0, 3) == 0);
      dat = m_rd[g] ? 1'b1 : 1'($urandom);
      d = 8'($urandom);
      lat = $urandom_range(0, 10);
      drop = ($urandom_range(0, 3) == 0);
      if (drop) req_valid[g] = 1'b0;
      finish_txn(lat, err, dat, d, rv, rd, re, rt, stable, extra);
      exp_rd = m_rd[g];
      checks++; if (rv !== 4'(1 << g) || re !== err || rt !== 1'b0 ||
                    rd !== (exp_rd ? d : 8'h00) || !stable || extra !== 0) begin
        errors++; $display("FAIL rand_rsp%0d: got rv=%0b err=%0b tmo=%0b rd=%0h stable=%0b exp rv=%0b err=%0b tmo=0 rd=%0h stable=1",
                           t, rv, re, rt, rd, stable, 4'(1 << g), err, exp_rd ? d : 8'h00);
      end
      retire(g);
    end
    req_valid = '0;
    m_pend = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid_wait();
    int cyc, extra; bit stable; logic [N-1:0] rv; logic [7:0] rd; logic re, rt; bit saw_rsp;
    do_reset();
    set_req(0, 1'b0, 7'h05, 8'h06);
    wait_launch(cyc);
    finish_txn(1, 1'b0, 1'b0, 8'h00, rv, rd, re, rt, stable, extra);
    retire(0);
    set_req(1, 1'b1, 7'h44, 8'h00);
    wait_launch(cyc);
    step();
    step();
    rst = 1'b1;
    set_req(0, 1'b0, 7'h12, 8'h34);
    step();
    checks++; if ({rsp_valid, busy, grant_id, read, slave_address, data_send_master,
                   data_send_master_enable, rsp_rdata, rsp_error, rsp_timeout} !== '0) begin
      errors++; $display("FAIL rstwait_outs: got rv=%0h busy=%0b gid=%0d sa=%0h exp all 0", rsp_valid,
                         busy, grant_id, slave_address);
    end
    rst = 1'b0;
    m_ptr = 0;
    saw_rsp = 1'b0;
    cyc = 0;
    while (!data_send_master_enable && cyc < 200) begin
      if (rsp_valid !== '0) saw_rsp = 1'b1;
      step();
      cyc++;
    end
    checks++; if (cyc !== 1 || grant_id !== 3'(model_pick()) || saw_rsp) begin
      errors++; $display("FAIL rstwait_next_grant: got cyc=%0d gid=%0d rsp=%0b exp 1/%0d/0", cyc,
                         grant_id, saw_rsp, model_pick());
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int cyc, n; bit saw_rsp;
    set_req(3, 1'b0, 7'h7F, 8'h81);
    wait_launch(cyc);
`ifdef I2C_ARB_TIMEOUT_EN
    n = 0;
    while (rsp_valid === '0 && n < 200) begin
      step();
      n++;
    end
    checks++; if (n !== 65 || rsp_valid !== 4'b1000 || rsp_error !== 1'b1 || rsp_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp: got n=%0d rv=%0b err=%0b tmo=%0b exp 65/1000/1/1", n,
                         rsp_valid, rsp_error, rsp_timeout);
    end
    saw_rsp = 1'b1;
`else
    saw_rsp = 1'b0;
    for (n = 0; n < 150; n++) begin
      step();
      if (rsp_valid !== '0) saw_rsp = 1'b1;
    end
    checks++; if (busy !== 1'b1 || saw_rsp) begin
      errors++; $display("FAIL no_timeout_stall: got busy=%0b rsp=%0b exp 1/0", busy, saw_rsp);
    end
`endif
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_read = '0;
    req_addr = '0;
    req_wdata = '0;
    data_receive_master = '0;
    data_receive_master_enable = 1'b0;
    error_master = 1'b0;
    done_master = 1'b0;
    m_pend = '0;
    m_ptr = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_error();
    test_round_robin();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
